// File: rtl/multiply_fix_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : multiply_fix_pipe
//  Purpose  : Pipelined fixed-point multiplier with AXI-Stream style ports.
//             It computes A*B and moves the binary point by OUTADDR, with
//             optional rounding, saturation and zero substitution. A range
//             flag is reported on tuser.
//  Revision : 1.0 - initial release
// ============================================================================
module multiply_fix_pipe #(
  parameter int DATAWIDTH_IN  = 32,
  parameter int DATAWIDTH_OUT = 60,
  parameter int OUTADDR       = 4,
  parameter int INVERSE       = 0,
  parameter int SIGNED        = 0,
  parameter int ROUND         = 0,
  parameter int SATURATE      = 0,
  parameter int ZERO_SUB      = 1,
  parameter int LATENCY       = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_a_tvalid,
  input  logic [DATAWIDTH_IN-1:0]  s_axis_a_tdata,
  output logic                     s_axis_a_tready,
  input  logic                     s_axis_b_tvalid,
  input  logic [DATAWIDTH_IN-1:0]  s_axis_b_tdata,
  output logic                     s_axis_b_tready,
  output logic                     m_axis_result_tvalid,
  input  logic                     m_axis_result_tready,
  output logic [DATAWIDTH_OUT-1:0] m_axis_result_tdata,
  output logic                     m_axis_result_tuser
);

  // Full product width, shift-safe intermediate width, and range-check width.
  localparam int C_PW = 2 * DATAWIDTH_IN;
  localparam int C_IW = C_PW + OUTADDR + 1;
  localparam int C_EW = ((C_IW > DATAWIDTH_OUT) ? C_IW : DATAWIDTH_OUT) + 1;

  logic                     stall;
  logic                     accept_d;
  logic signed [C_PW-1:0]   a_ext;
  logic signed [C_PW-1:0]   b_ext;
  logic [C_PW-1:0]          prod_d;
  logic [C_PW-1:0]          prod_q [LATENCY];
  logic [LATENCY-1:0]       valid_q;

  logic [C_PW-1:0]          p_last;
  logic signed [C_IW-1:0]   p_ext;
  logic signed [C_IW-1:0]   q_shr;
  logic signed [C_IW-1:0]   q_val;
  logic                     rnd_bit;
  logic [C_EW-1:0]          q_wide;
  logic [C_EW-DATAWIDTH_OUT:0]   top_s;
  logic [C_EW-DATAWIDTH_OUT-1:0] top_u;
  logic                     ovf;
  logic [DATAWIDTH_OUT-1:0] sat_val;
  logic [DATAWIDTH_OUT-1:0] res_sel;
  logic [DATAWIDTH_OUT-1:0] res_fin;

  // Reset forces stall low so the input side looks ready while being flushed.
  assign stall           = valid_q[LATENCY-1] & ~m_axis_result_tready & ~areset;
  assign s_axis_a_tready = ~stall;
  assign s_axis_b_tready = ~stall;
  assign accept_d        = s_axis_a_tvalid & s_axis_b_tvalid & ~stall;

  // Operands are widened to the full product width so a single multiply
  // yields the exact 2N-bit result in either encoding.
  if (SIGNED != 0) begin : g_ext_signed
    assign a_ext = {{DATAWIDTH_IN{s_axis_a_tdata[DATAWIDTH_IN-1]}}, s_axis_a_tdata};
    assign b_ext = {{DATAWIDTH_IN{s_axis_b_tdata[DATAWIDTH_IN-1]}}, s_axis_b_tdata};
  end else begin : g_ext_unsigned
    assign a_ext = {{DATAWIDTH_IN{1'b0}}, s_axis_a_tdata};
    assign b_ext = {{DATAWIDTH_IN{1'b0}}, s_axis_b_tdata};
  end

  assign prod_d = a_ext * b_ext;

  // Product/valid shift register; every stage freezes together on stall.
  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) prod_q[i] <= '0;
    end else if (!stall) begin
      valid_q[0] <= accept_d;
      prod_q[0]  <= prod_d;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        prod_q[i]  <= prod_q[i-1];
      end
    end
  end

  // Post-processing works on the last stage, so held outputs stay stable.
  assign p_last = prod_q[LATENCY-1];
  assign p_ext  = (SIGNED != 0) ? {{(C_IW-C_PW){p_last[C_PW-1]}}, p_last}
                                : {{(C_IW-C_PW){1'b0}}, p_last};

  // Round-half-up adds the highest bit shifted out (extended bit for big shifts).
  if ((ROUND != 0) && (OUTADDR > 0) && (INVERSE == 0)) begin : g_round
    assign rnd_bit = p_ext[OUTADDR-1];
  end else begin : g_no_round
    assign rnd_bit = 1'b0;
  end

  // Shift kept separate from the rounding add so >>> stays arithmetic.
  assign q_shr = (INVERSE != 0) ? (p_ext <<< OUTADDR) : (p_ext >>> OUTADDR);
  assign q_val = q_shr + {{(C_IW-1){1'b0}}, rnd_bit};
  assign q_wide = {{(C_EW-C_IW){q_val[C_IW-1]}}, q_val};
  assign top_s  = q_wide[C_EW-1:DATAWIDTH_OUT-1];
  assign top_u  = q_wide[C_EW-1:DATAWIDTH_OUT];

  // Range check, clamp/wrap selection and zero substitution.
  always_comb begin
    ovf     = 1'b0;
    sat_val = '1;
    if (SIGNED != 0) begin
      ovf     = ~((&top_s) | ~(|top_s));
      sat_val = q_wide[C_EW-1] ? {1'b1, {(DATAWIDTH_OUT-1){1'b0}}}
                               : {1'b0, {(DATAWIDTH_OUT-1){1'b1}}};
    end else begin
      ovf = |top_u;
    end
    res_sel = (ovf && (SATURATE != 0)) ? sat_val : q_wide[DATAWIDTH_OUT-1:0];
    res_fin = res_sel;
    if ((ZERO_SUB != 0) && (res_sel == '0)) begin
      res_fin = {{(DATAWIDTH_OUT-1){1'b0}}, 1'b1};
    end
  end

  // Idle output is forced to zero so stale pipeline data never leaks out.
  assign m_axis_result_tvalid = valid_q[LATENCY-1];
  assign m_axis_result_tdata  = valid_q[LATENCY-1] ? res_fin : '0;
  assign m_axis_result_tuser  = valid_q[LATENCY-1] & ovf;

endmodule
`default_nettype wire

// File: tb/tb_multiply_fix_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_multiply_fix_pipe
//  Purpose  : Scoreboard bench for multiply_fix_pipe. Four configurations
//             share one input stream; expected results are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiply_fix_pipe;

  localparam int DIN = 8;
  localparam int DOUT = 8;
  localparam int OA = 4;
  localparam int LAT = 3;
  localparam int NU = 4;
  localparam int NV = 9;

  // Instances: 0 unsigned/sat/zsub, 1 unsigned/round/wrap,
  //            2 signed/sat, 3 signed/left-shift/wrap/zsub.
  localparam logic [7:0]  VA [NV] = '{8'h30, 8'hFF, 8'hF0, 8'h03, 8'h80, 8'h07, 8'h00, 8'hFE, 8'hFF};
  localparam logic [7:0]  VB [NV] = '{8'h20, 8'hFF, 8'h10, 8'h05, 8'h7F, 8'h09, 8'h55, 8'h03, 8'h10};
  // Expected tdata, instance 0 in the top byte.
  localparam logic [31:0] ED [NV] = '{32'h60606001, 32'hFFE00010, 32'hF0F0F001,
                                      32'h010100F0, 32'hFFF88001, 32'h030403F0,
                                      32'h01000001, 32'h2F30FFA0, 32'hFFFFFF01};
  // Expected tuser, instance 0 in the top bit.
  localparam logic [3:0]  EF [NV] = '{4'b0001, 4'b1100, 4'b0001, 4'b0001, 4'b1111,
                                      4'b0001, 4'b0000, 4'b0000, 4'b0001};

  typedef struct {
    int idx;
    int acc;
    int st;
  } exp_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic a_v = 1'b0;
  logic b_v = 1'b0;
  logic rdy = 1'b1;
  logic [7:0] a_d = '0;
  logic [7:0] b_d = '0;
  logic a_r [NU];
  logic b_r [NU];
  logic o_v [NU];
  logic o_u [NU];
  logic [7:0] o_d [NU];
  logic [7:0] pd [NU];
  logic pu [NU];
  logic pv [NU];

  exp_t sbq [$];
  int cyc = 0;
  int stall_cnt = 0;
  int checks = 0;
  int failures = 0;
  bit prev_stall = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    multiply_fix_pipe #(
      .DATAWIDTH_IN (DIN),
      .DATAWIDTH_OUT(DOUT),
      .OUTADDR      (OA),
      .INVERSE      ((g == 3) ? 1 : 0),
      .SIGNED       ((g >= 2) ? 1 : 0),
      .ROUND        ((g == 1) ? 1 : 0),
      .SATURATE     ((g == 0 || g == 2) ? 1 : 0),
      .ZERO_SUB     ((g == 0 || g == 3) ? 1 : 0),
      .LATENCY      (LAT)
    ) u_dut (
      .aclk                (clk),
      .areset              (areset),
      .s_axis_a_tvalid     (a_v),
      .s_axis_a_tdata      (a_d),
      .s_axis_a_tready     (a_r[g]),
      .s_axis_b_tvalid     (b_v),
      .s_axis_b_tdata      (b_d),
      .s_axis_b_tready     (b_r[g]),
      .m_axis_result_tvalid(o_v[g]),
      .m_axis_result_tready(rdy),
      .m_axis_result_tdata (o_d[g]),
      .m_axis_result_tuser (o_u[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one beat and hold it until the handshake; record the expectation.
  task automatic send(input int i);
    bit done = 1'b0;
    a_d = VA[i];
    b_d = VB[i];
    a_v = 1'b1;
    b_v = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (a_r[0] && b_r[0] && !areset) begin
        sbq.push_back('{i, cyc, stall_cnt});
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout vector=%0d actual=not_accepted required=accepted", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sbq.size() != 0; t++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", sbq.size());
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Drop result ready for 5 cycles starting with the first valid result.
  task automatic bp();
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk);
      #1;
      if (o_v[0]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bp_wait actual=no_tvalid required=tvalid");
    end
    rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rdy = 1'b1;
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on handshake.
  initial begin : monitor
    exp_t e;
    logic [31:0] ew;
    logic [3:0] ef;
    forever begin
      @(negedge clk);
      if (areset) begin
        sbq.delete();
        prev_stall = 1'b0;
        for (int g = 0; g < NU; g++) begin
          chk("rst_a_tready", a_r[g], 1);
          chk("rst_b_tready", b_r[g], 1);
        end
      end else begin
        for (int g = 0; g < NU; g++) begin
          if (g > 0) chk("tvalid_agree", o_v[g], o_v[0]);
          if (!o_v[g]) begin
            chk("idle_tdata", o_d[g], 0);
            chk("idle_tuser", o_u[g], 0);
          end
          if (prev_stall) begin
            chk("hold_tvalid", o_v[g], pv[g]);
            chk("hold_tdata", o_d[g], pd[g]);
            chk("hold_tuser", o_u[g], pu[g]);
          end
          chk("a_tready", a_r[g], !(o_v[g] && !rdy));
          chk("b_tready", b_r[g], !(o_v[g] && !rdy));
        end
        if (o_v[0] && rdy) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=tvalid tdata=0x%0h required=no_result", o_d[0]);
          end else begin
            e  = sbq.pop_front();
            ew = ED[e.idx];
            ef = EF[e.idx];
            for (int g = 0; g < NU; g++) begin
              chk($sformatf("tdata_v%0d_u%0d", e.idx, g), o_d[g], ew[8*(3-g) +: 8]);
              chk($sformatf("tuser_v%0d_u%0d", e.idx, g), o_u[g], ef[3-g]);
            end
            chk($sformatf("latency_v%0d", e.idx), cyc, e.acc + LAT + (stall_cnt - e.st));
          end
        end
        prev_stall = o_v[0] && !rdy;
        if (prev_stall) stall_cnt++;
        for (int g = 0; g < NU; g++) begin
          pd[g] = o_d[g];
          pu[g] = o_u[g];
          pv[g] = o_v[g];
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Beats presented during reset must be ignored.
    a_d = VA[1];
    b_d = VB[1];
    a_v = 1'b1;
    b_v = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    idle();
    for (int g = 0; g < NU; g++) begin
      chk("post_rst_tvalid", o_v[g], 0);
      chk("post_rst_tdata", o_d[g], 0);
      chk("post_rst_tuser", o_u[g], 0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Single beat, then a short burst.
    send(0);
    idle();
    drain();
    send(1);
    send(2);
    send(3);
    idle();
    drain();

    // Six back-to-back beats with a 5-cycle output stall.
    fork
      bp();
      begin
        send(4);
        send(5);
        send(6);
        send(7);
        send(8);
        send(0);
        idle();
      end
    join
    drain();

    // Join: A alone for 4 cycles, then B arrives.
    a_d = VA[5];
    b_d = 8'h00;
    a_v = 1'b1;
    b_v = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(5);
    idle();
    drain();

    // Reset with two beats in flight, then a fresh beat.
    send(6);
    send(7);
    idle();
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    for (int g = 0; g < NU; g++) chk("flush_tvalid", o_v[g], 0);
    send(8);
    idle();
    drain();
    repeat (8) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
